ula_seq: RTL and testbench

- Multi-cycle issue/writeback controller that drives the 16-bit ALU (ula).
- Accepts 16-bit instructions over a valid/ready handshake and holds an 8x16 register file.
- Reads operands, presents op/in0/in1 to the ALU, captures the ALU result and writes it back.
- Sits between the instruction source (test program / fetch stage) and the combinational ALU.

---
 rtl/ula_pkg.sv | 35 +++
 rtl/regfile_8x16.sv | 53 +++++
 rtl/ula_seq.sv | 129 ++++++++++++
 tb/tb_ula_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the ula_seq issue/writeback controller: ALU op codes,
// FSM state encoding and instruction field positions.
package ula_pkg;

   localparam int ULA_DATA_W = 16;
   localparam int ULA_NREG   = 8;
   localparam int REG_AW     = 3;
   localparam int INSTR_W    = 16;
   localparam int IMM_W      = 10;

   localparam logic [2:0] ULA_ADD = 3'b000;
   localparam logic [2:0] ULA_SUB = 3'b001;
   localparam logic [2:0] ULA_SLL = 3'b010;
   localparam logic [2:0] ULA_SRL = 3'b011;
   localparam logic [2:0] ULA_OR  = 3'b100;
   localparam logic [2:0] ULA_SLT = 3'b101;

   localparam int F_OP_LSB = 13;
   localparam int F_RD_LSB = 10;
   localparam int F_RS_LSB = 7;
   localparam int F_RT_LSB = 4;
   localparam int F_LI_BIT = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_EXEC = 2'd2,
      ST_WB   = 2'd3
   } state_e;

   function automatic logic [2:0] fld3(input logic [INSTR_W-1:0] w, input int lsb);
      return w[lsb +: 3];
   endfunction

endpackage

// File: rtl/regfile_8x16.sv
// Register file: two combinational operand read ports, one debug read port,
// one synchronous write port. Build macro ULA_SEQ_ZERO_REG_EN hardwires reg[0] to zero.
module regfile_8x16
   import ula_pkg::*;
#(
   parameter int DATA_W = ULA_DATA_W,
   parameter int NREG   = ULA_NREG
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [REG_AW-1:0] i_ra0,
   input  logic [REG_AW-1:0] i_ra1,
   input  logic [REG_AW-1:0] i_rad,
   output logic [DATA_W-1:0] o_rd0,
   output logic [DATA_W-1:0] o_rd1,
   output logic [DATA_W-1:0] o_rdd,
   input  logic              i_we,
   input  logic [REG_AW-1:0] i_wa,
   input  logic [DATA_W-1:0] i_wd
);

   logic [DATA_W-1:0] r_mem [NREG];
   logic              w_wr_en;

`ifdef ULA_SEQ_ZERO_REG_EN
   assign w_wr_en = i_we && (i_wa != '0);
`else
   assign w_wr_en = i_we;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_mem[i_wa] <= i_wd;
      end
   end

   // No write bypass: a write becomes visible on the reads only after its edge.
   always_comb begin
      o_rd0 = r_mem[i_ra0];
      o_rd1 = r_mem[i_ra1];
      o_rdd = r_mem[i_rad];
`ifdef ULA_SEQ_ZERO_REG_EN
      if (i_ra0 == '0) o_rd0 = '0;
      if (i_ra1 == '0) o_rd1 = '0;
      if (i_rad == '0) o_rdd = '0;
`endif
   end

endmodule

// File: rtl/ula_seq.sv
// Multi-cycle issue/writeback controller for the external 16-bit ALU (ula).
// Optional build macro ULA_SEQ_ZERO_REG_EN (handled in regfile_8x16) makes reg[0] read as zero.
//
// state   | meaning
// IDLE    | instr_ready=1, waiting for instr_valid; instruction latched on accept
// READ    | operands read from regfile, registered onto alu_a/alu_b/alu_op
// EXEC    | ALU settles; alu_out captured into the result register
// WB      | result written to reg[rd]; done pulses with wb_addr/wb_data
module ula_seq
   import ula_pkg::*;
#(
   parameter int DATA_W = ULA_DATA_W,
   parameter int NREG   = ULA_NREG
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [INSTR_W-1:0] instr,
   input  logic               instr_valid,
   output logic               instr_ready,
   output logic [2:0]         alu_op,
   output logic [DATA_W-1:0]  alu_a,
   output logic [DATA_W-1:0]  alu_b,
   input  logic [DATA_W-1:0]  alu_out,
   output logic               done,
   output logic [REG_AW-1:0]  wb_addr,
   output logic [DATA_W-1:0]  wb_data,
   input  logic [REG_AW-1:0]  dbg_addr,
   output logic [DATA_W-1:0]  dbg_data
);

   state_e             r_state;
   state_e             w_state_nxt;

   logic [2:0]         r_op;
   logic [REG_AW-1:0]  r_rd;
   logic [REG_AW-1:0]  r_rs;
   logic [REG_AW-1:0]  r_rt;
   logic [2:0]         r_alu_op;
   logic [DATA_W-1:0]  r_alu_a;
   logic [DATA_W-1:0]  r_alu_b;
   logic [DATA_W-1:0]  r_result;

   logic               w_accept;
   logic               w_li;
   logic [DATA_W-1:0]  w_imm;
   logic [DATA_W-1:0]  w_rd0;
   logic [DATA_W-1:0]  w_rd1;
   logic               w_wb;

   assign w_accept = (r_state == ST_IDLE) && instr_valid;
   assign w_li     = instr[F_LI_BIT];
   // The immediate is instr[9:0] taken verbatim, so it includes the li flag bit.
   assign w_imm    = {{(DATA_W-IMM_W){1'b0}}, instr[IMM_W-1:0]};
   assign w_wb     = (r_state == ST_WB);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_op     <= ULA_ADD;
         r_rd     <= '0;
         r_rs     <= '0;
         r_rt     <= '0;
         r_alu_op <= ULA_ADD;
         r_alu_a  <= '0;
         r_alu_b  <= '0;
         r_result <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_op <= fld3(instr, F_OP_LSB);
            r_rd <= fld3(instr, F_RD_LSB);
            r_rs <= fld3(instr, F_RS_LSB);
            r_rt <= fld3(instr, F_RT_LSB);
            if (w_li) begin
               r_result <= w_imm;
            end
         end
         if (r_state == ST_READ) begin
            r_alu_op <= r_op;
            r_alu_a  <= w_rd0;
            r_alu_b  <= w_rd1;
         end
         if (r_state == ST_EXEC) begin
            r_result <= alu_out;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (instr_valid) begin
               w_state_nxt = w_li ? ST_WB : ST_READ;
            end
         end
         ST_READ: w_state_nxt = ST_EXEC;
         ST_EXEC: w_state_nxt = ST_WB;
         ST_WB:   w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   regfile_8x16 #(
      .DATA_W (DATA_W),
      .NREG   (NREG)
   ) u_regfile (
      .clock (clock),
      .reset (reset),
      .i_ra0 (r_rs),
      .i_ra1 (r_rt),
      .i_rad (dbg_addr),
      .o_rd0 (w_rd0),
      .o_rd1 (w_rd1),
      .o_rdd (dbg_data),
      .i_we  (w_wb),
      .i_wa  (r_rd),
      .i_wd  (r_result)
   );

   assign instr_ready = (r_state == ST_IDLE);
   assign alu_op      = r_alu_op;
   assign alu_a       = r_alu_a;
   assign alu_b       = r_alu_b;
   assign done        = w_wb;
   assign wb_addr     = r_rd;
   assign wb_data     = r_result;

endmodule

// File: tb/tb_ula_seq.sv
// Directed self-checking bench for ula_seq with a behavioural ALU beside it.
module tb_ula_seq;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [2:0]  alu_op;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [15:0] alu_out;
   logic        done;
   logic [2:0]  wb_addr;
   logic [15:0] wb_data;
   logic [2:0]  dbg_addr;
   logic [15:0] dbg_data;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   ula_seq dut (
      .clock       (clock),
      .reset       (reset),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .alu_op      (alu_op),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_out     (alu_out),
      .done        (done),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data)
   );

   always_comb begin
      case (alu_op)
         3'b000:  alu_out = alu_a + alu_b;
         3'b001:  alu_out = alu_a - alu_b;
         3'b010:  alu_out = alu_a << alu_b[3:0];
         3'b011:  alu_out = alu_a >> alu_b[3:0];
         3'b100:  alu_out = alu_a | alu_b;
         default: alu_out = {15'b0, ($signed(alu_a) < $signed(alu_b))};
      endcase
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs, input logic [2:0] rt);
      return {op, rd, rs, rt, 4'b0000};
   endfunction

   // imm must have bit 3 set: that bit is the li flag.
   function automatic logic [15:0] enc_li(input logic [2:0] rd, input logic [9:0] imm);
      return {3'b000, rd, imm};
   endfunction

   task automatic issue(input string tag, input logic [15:0] w, input int exp_lat,
                        input logic [2:0] exp_addr, input logic [15:0] exp_data);
      int waitc;
      int lat;
      waitc = 0;
      lat   = 0;
      @(negedge clock);
      instr       = w;
      instr_valid = 1'b1;
      while (!instr_ready && waitc < 20) begin
         @(negedge clock);
         waitc++;
      end
      check({tag, "_ready_wait"}, 16'(waitc < 20), 16'd1);
      @(posedge clock);
      #1 instr_valid = 1'b0;
      for (int k = 1; k <= 8 && lat == 0; k++) begin
         @(negedge clock);
         if (done) begin
            lat = k;
            check({tag, "_wb_addr"}, 16'(wb_addr), 16'(exp_addr));
            check({tag, "_wb_data"}, wb_data, exp_data);
         end
      end
      check({tag, "_latency"}, 16'(lat), 16'(exp_lat));
   endtask

   task automatic dbg_check(input string tag, input logic [2:0] a, input logic [15:0] exp);
      @(posedge clock);
      #1 dbg_addr = a;
      @(negedge clock);
      check(tag, dbg_data, exp);
   endtask

   localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, SLL = 3'b010,
                          SRL = 3'b011, OR_ = 3'b100, SLT = 3'b101;

   initial begin
      int ndone;
      reset       = 1'b1;
      instr       = 16'h0000;
      instr_valid = 1'b0;
      dbg_addr    = 3'd0;
      @(posedge clock);
      @(negedge clock);
      check("rst_ready",   16'(instr_ready), 16'd1);
      check("rst_done",    16'(done), 16'd0);
      check("rst_wb_addr", 16'(wb_addr), 16'd0);
      check("rst_wb_data", wb_data, 16'h0000);
      check("rst_alu_op",  16'(alu_op), 16'd0);
      check("rst_alu_a",   alu_a, 16'h0000);
      check("rst_alu_b",   alu_b, 16'h0000);
      check("rst_dbg_r0",  dbg_data, 16'h0000);
      @(posedge clock);
      #1 reset = 1'b0;

      // r1 = 0x000D, r2 = 0x000B
      issue("li_r1", enc_li(3'd1, 10'h00D), 1, 3'd1, 16'h000D);
      issue("li_r2", enc_li(3'd2, 10'h00B), 1, 3'd2, 16'h000B);
      dbg_check("dbg_r1", 3'd1, 16'h000D);
      dbg_check("dbg_r2", 3'd2, 16'h000B);

      issue("add_r3", enc(ADD, 3'd3, 3'd1, 3'd2), 3, 3'd3, 16'h0018);
      issue("sub_r4", enc(SUB, 3'd4, 3'd2, 3'd1), 3, 3'd4, 16'hFFFE);
      issue("slt_t",  enc(SLT, 3'd5, 3'd2, 3'd1), 3, 3'd5, 16'h0001);
      issue("slt_f",  enc(SLT, 3'd5, 3'd1, 3'd2), 3, 3'd5, 16'h0000);
      issue("sll_r6", enc(SLL, 3'd6, 3'd1, 3'd2), 3, 3'd6, 16'h6800);
      issue("srl_r6", enc(SRL, 3'd6, 3'd6, 3'd2), 3, 3'd6, 16'h000D);
      issue("or_r7",  enc(OR_, 3'd7, 3'd1, 3'd2), 3, 3'd7, 16'h000F);
      dbg_check("dbg_r3", 3'd3, 16'h0018);
      dbg_check("dbg_r4", 3'd4, 16'hFFFE);
      check("hold_alu_op", 16'(alu_op), 16'(OR_));
      check("hold_alu_a",  alu_a, 16'h000D);
      check("hold_alu_b",  alu_b, 16'h000B);

      // Back-pressure: valid held high through READ/EXEC/WB, then a second instr follows.
      dbg_addr = 3'd1;
      @(negedge clock);
      instr       = enc(ADD, 3'd1, 3'd1, 3'd1);
      instr_valid = 1'b1;
      check("bp_ready_idle", 16'(instr_ready), 16'd1);
      ndone = 0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clock);
         check($sformatf("bp_ready_busy%0d", k), 16'(instr_ready), 16'd0);
         if (done) ndone++;
      end
      check("bp_wb_data", wb_data, 16'h001A);
      check("bp_no_bypass", dbg_data, 16'h000D);
      instr = enc_li(3'd4, 10'h0F8);
      @(negedge clock);
      check("bp_ready_after", 16'(instr_ready), 16'd1);
      check("bp_dbg_r1", dbg_data, 16'h001A);
      if (done) ndone++;
      @(negedge clock);
      if (done) ndone++;
      check("bp_li_wb_addr", 16'(wb_addr), 16'd4);
      check("bp_li_wb_data", wb_data, 16'h00F8);
      instr_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         if (done) ndone++;
      end
      check("bp_done_count", 16'(ndone), 16'd2);
      dbg_check("bp_dbg_r4", 3'd4, 16'h00F8);

      // Reset during EXEC of ADD r3,r1,r2.
      @(negedge clock);
      instr       = enc(ADD, 3'd3, 3'd1, 3'd2);
      instr_valid = 1'b1;
      @(posedge clock);
      #1 instr_valid = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("mr_done_in_rst", 16'(done), 16'd0);
      @(negedge clock);
      check("mr_ready_after", 16'(instr_ready), 16'd1);
      check("mr_alu_a", alu_a, 16'h0000);
      ndone = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         if (done) ndone++;
      end
      check("mr_no_done", 16'(ndone), 16'd0);
      dbg_check("mr_dbg_r3", 3'd3, 16'h0000);
      dbg_check("mr_dbg_r1", 3'd1, 16'h0000);

      // Register 0 behaviour depends on ULA_SEQ_ZERO_REG_EN.
      issue("li_r0", enc_li(3'd0, 10'h00F), 1, 3'd0, 16'h000F);
`ifdef ULA_SEQ_ZERO_REG_EN
      dbg_check("dbg_r0", 3'd0, 16'h0000);
      issue("add_r0r0", enc(ADD, 3'd1, 3'd0, 3'd0), 3, 3'd1, 16'h0000);
      dbg_check("dbg_r1_zero", 3'd1, 16'h0000);
`else
      dbg_check("dbg_r0", 3'd0, 16'h000F);
      issue("add_r0r0", enc(ADD, 3'd1, 3'd0, 3'd0), 3, 3'd1, 16'h001E);
      dbg_check("dbg_r1_zero", 3'd1, 16'h001E);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
